agendador_rega: RTL and testbench

AGENDADOR_REGA -- requirements
Module: agendador_rega

---
 rtl/regador_pkg.sv | 13 +
 rtl/contador_planta.sv | 32 +++
 rtl/agendador_rega.sv | 92 +++++++++
 tb/tb_agendador_rega.sv | 97 +++++++++
 4 files changed

// File: rtl/regador_pkg.sv
// regador_pkg: shared constants, plant index type and FSM states for the watering scheduler
package regador_pkg;
  localparam int NUM_PLANTAS = 3;
  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t NENHUMA = 2'd3;
  typedef enum logic [1:0] {OCIOSO, REGANDO, PAUSA} estado_t;
  localparam int T_REGA_DEF = 600;
  localparam int T_PAUSA_DEF = 120;
  function automatic idx_t proxima(input idx_t i);
    return (i == idx_t'(NUM_PLANTAS - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/contador_planta.sv
// contador_planta: per-plant period/day counter with sticky pending flag; config beats day tick
module contador_planta (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_dia,
  input  logic       cfg_we,
  input  logic [3:0] cfg_periodo,
  input  logic       clr,
  output logic       pendente
);
  logic [3:0] periodo_q, periodo_d, contador_q, contador_d;
  logic pendente_q, pendente_d, ativa, vence;
  always_comb begin
    ativa = tick_dia && (periodo_q != '0);
    vence = ativa && (contador_q <= 4'd1);
    periodo_d = cfg_we ? cfg_periodo : periodo_q;
    contador_d = cfg_we ? cfg_periodo : vence ? periodo_q : ativa ? contador_q - 4'd1 : contador_q;
    pendente_d = cfg_we ? 1'b0 : vence ? 1'b1 : clr ? 1'b0 : pendente_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      periodo_q <= '0;
      contador_q <= '0;
      pendente_q <= 1'b0;
    end else begin
      periodo_q <= periodo_d;
      contador_q <= contador_d;
      pendente_q <= pendente_d;
    end
  end
  assign pendente = pendente_q;
endmodule

// File: rtl/agendador_rega.sv
// agendador_rega: round-robin watering scheduler, one pump at a time with a guard pause
module agendador_rega
  import regador_pkg::*;
#(
  parameter int T_REGA  = T_REGA_DEF,
  parameter int T_PAUSA = T_PAUSA_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_dia,
  input  logic       cfg_we,
  input  logic [1:0] cfg_planta,
  input  logic [3:0] cfg_periodo,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3,
  output logic       ocupado,
  output logic [1:0] planta_ativa
);
  localparam int CW = $clog2((T_REGA > T_PAUSA ? T_REGA : T_PAUSA) + 1);
  estado_t estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  idx_t sel_q, sel_d, ult_q, ult_d, planta_q, planta_d, c1, c2, escolha;
  logic [NUM_PLANTAS-1:0] pend, clr, pump_q, pump_d;
  logic ocupado_q, ocupado_d, aborta;
  for (genvar i = 0; i < NUM_PLANTAS; i++) begin : g_planta
    contador_planta u_planta (
      .clk(clk),
      .rst(rst),
      .tick_dia(tick_dia),
      .cfg_we(cfg_we && cfg_planta == idx_t'(i)),
      .cfg_periodo(cfg_periodo),
      .clr(clr[i]),
      .pendente(pend[i])
    );
  end
  always_comb begin
    c1 = proxima(ult_q);
    c2 = proxima(c1);
    escolha = pend[c1] ? c1 : pend[c2] ? c2 : ult_q;
    aborta = cfg_we && cfg_planta == sel_q && cfg_periodo == '0;
    estado_d = estado_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    ult_d = ult_q;
    clr = '0;
    case (estado_q)
      OCIOSO: if (|pend) begin
        estado_d = REGANDO;
        sel_d = escolha;
        ult_d = escolha;
        clr[escolha] = 1'b1;
        cnt_d = CW'(T_REGA - 1);
      end
      REGANDO: if (aborta || cnt_q == '0) begin
        estado_d = PAUSA;
        cnt_d = CW'(T_PAUSA - 1);
      end else cnt_d = cnt_q - 1'b1;
      PAUSA: if (cnt_q <= CW'(1)) begin
        estado_d = OCIOSO;
        cnt_d = '0;
      end else cnt_d = cnt_q - 1'b1;
      default: estado_d = OCIOSO;
    endcase
    // the idle grant cycle counts toward the pumps-off guard interval
    pump_d = (estado_d == REGANDO) ? NUM_PLANTAS'(1) << sel_d : '0;
    planta_d = (estado_d == REGANDO) ? sel_d : NENHUMA;
    ocupado_d = estado_d != OCIOSO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      cnt_q <= '0;
      sel_q <= '0;
      ult_q <= idx_t'(NUM_PLANTAS - 1);
      pump_q <= '0;
      ocupado_q <= 1'b0;
      planta_q <= NENHUMA;
    end else begin
      estado_q <= estado_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      ult_q <= ult_d;
      pump_q <= pump_d;
      ocupado_q <= ocupado_d;
      planta_q <= planta_d;
    end
  end
  assign {pump3, pump2, pump1} = pump_q;
  assign ocupado = ocupado_q;
  assign planta_ativa = planta_q;
endmodule

// File: tb/tb_agendador_rega.sv
// tb_agendador_rega: cycle-exact vector table with a one-cycle expected-output scoreboard
module tb_agendador_rega;
  logic clk = 1'b0, rst = 1'b1, tick_dia = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_planta = '0;
  logic [3:0] cfg_periodo = '0;
  logic pump1, pump2, pump3, ocupado;
  logic [1:0] planta_ativa;
  typedef struct {
    logic t, w;
    logic [1:0] p;
    logic [3:0] d;
    logic r;
    logic [1:0] ep;
    logic eo;
  } vec_t;
  vec_t vecs[$];
  int exp_q[$];
  int n_vec = 0, n_err = 0;
  agendador_rega #(.T_REGA(4), .T_PAUSA(2)) dut (
    .clk(clk), .rst(rst), .tick_dia(tick_dia), .cfg_we(cfg_we), .cfg_planta(cfg_planta),
    .cfg_periodo(cfg_periodo), .pump1(pump1), .pump2(pump2), .pump3(pump3),
    .ocupado(ocupado), .planta_ativa(planta_ativa)
  );
  always #5 clk = ~clk;
  task automatic a(input int n, input logic t, input logic w, input logic [1:0] p,
                   input logic [3:0] d, input logic r, input logic [1:0] ep, input logic eo);
    vec_t v;
    v = '{t: t, w: w, p: p, d: d, r: r, ep: ep, eo: eo};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask
  task automatic idle(input int n); a(n, 0, 0, 0, 0, 0, 3, 0); endtask
  task automatic cfg(input logic [1:0] p, input logic [3:0] d); a(1, 0, 1, p, d, 0, 3, 0); endtask
  task automatic tk(); a(1, 1, 0, 0, 0, 0, 3, 0); endtask
  task automatic water(input int n, input logic [1:0] p); a(n, 0, 0, 0, 0, 0, p, 1); endtask
  task automatic serve(input logic [1:0] p); water(4, p); a(1, 0, 0, 0, 0, 0, 3, 1); idle(1); endtask
  task automatic check();
    int k;
    logic [2:0] want_pump;
    if (exp_q.size() == 0) return;
    k = exp_q.pop_front();
    n_vec++;
    want_pump = (vecs[k].ep == 2'd3) ? 3'b000 : 3'b001 << vecs[k].ep;
    if ({pump3, pump2, pump1} !== want_pump) begin
      n_err++;
      $display("FAIL vec %0d pumps: got %b want %b", k, {pump3, pump2, pump1}, want_pump);
    end
    if (ocupado !== vecs[k].eo) begin
      n_err++;
      $display("FAIL vec %0d ocupado: got %b want %b", k, ocupado, vecs[k].eo);
    end
    if (planta_ativa !== vecs[k].ep) begin
      n_err++;
      $display("FAIL vec %0d planta_ativa: got %0d want %0d", k, planta_ativa, vecs[k].ep);
    end
  endtask
  initial begin
    a(2, 0, 0, 0, 0, 1, 3, 0);
    cfg(0, 1); cfg(1, 1); cfg(2, 1);
    tk(); serve(0); serve(1); serve(2);
    cfg(0, 0); cfg(1, 0); cfg(2, 0);
    cfg(0, 1); cfg(1, 3);
    tk(); serve(0); idle(2);
    tk(); serve(0); idle(2);
    tk(); serve(1); serve(0);
    cfg(0, 0); cfg(1, 0);
    // cfg and tick in the same cycle: count restarts at 5, due only on the 5th tick
    cfg(2, 1);
    a(1, 1, 1, 2, 5, 0, 3, 0);
    idle(3);
    for (int i = 0; i < 4; i++) begin tk(); idle(1); end
    tk(); serve(2); cfg(2, 0);
    cfg(0, 1); tk(); water(1, 0);
    a(1, 0, 1, 0, 2, 0, 0, 1);
    water(2, 0); a(1, 0, 0, 0, 0, 0, 3, 1); idle(1); cfg(0, 0);
    cfg(1, 1); tk(); water(2, 1);
    a(1, 0, 1, 1, 0, 0, 3, 1);
    idle(1);
    for (int i = 0; i < 3; i++) begin tk(); idle(2); end
    cfg(1, 1); tk(); water(2, 1);
    a(1, 0, 0, 0, 0, 1, 3, 0);
    for (int i = 0; i < 2; i++) begin tk(); idle(2); end
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check();
      tick_dia = vecs[i].t;
      cfg_we = vecs[i].w;
      cfg_planta = vecs[i].p;
      cfg_periodo = vecs[i].d;
      rst = vecs[i].r;
      exp_q.push_back(i);
    end
    @(negedge clk);
    check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
